// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-back path.
package regfile_pkg;

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned NREGS = 32;

  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard for long-latency LDU destinations; flags RAW hazards on reads.
module wb_scoreboard
  import regfile_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue_valid_i,
  input  logic [AW-1:0] issue_addr_i,
  output logic          issue_ready_o,
  input  logic          commit_i,
  input  logic [AW-1:0] commit_addr_i,
  input  logic [AW-1:0] rd_addr0_i,
  input  logic [AW-1:0] rd_addr1_i,
  output logic          hazard_o
);

  logic [NREGS-1:0] pending_q, pending_d;
  logic             issue_hs;

  assign issue_ready_o = rst_n & ~pending_q[issue_addr_i];
  assign issue_hs      = issue_valid_i & issue_ready_o;
  assign hazard_o      = pending_q[rd_addr0_i] | pending_q[rd_addr1_i];

  // Clear first so a same-edge issue to the committing address keeps the bit set.
  always_comb begin
    pending_d = pending_q;
    if (commit_i) begin
      pending_d[commit_addr_i] = 1'b0;
    end
    if (issue_hs && (issue_addr_i != REG_ZERO)) begin
      pending_d[issue_addr_i] = 1'b1;
    end
    pending_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-port arbiter: ALU vs. LDU with LDU anti-starvation, registered
// write stage and a pending-write scoreboard for LDU destinations.
module regfile_wb_ctrl
  import regfile_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [AW-1:0] alu_addr,
  input  logic [DW-1:0] alu_data,
  input  logic          ldu_valid,
  output logic          ldu_ready,
  input  logic [AW-1:0] ldu_addr,
  input  logic [DW-1:0] ldu_data,
  input  logic          issue_valid,
  output logic          issue_ready,
  input  logic [AW-1:0] issue_addr,
  input  logic [AW-1:0] rd_addr0,
  input  logic [AW-1:0] rd_addr1,
  output logic          hazard,
  output logic          regWr,
  output logic [AW-1:0] addrWr,
  output logic [DW-1:0] wr_data
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_MAX);

  logic [CntW-1:0] starve_q, starve_d;
  logic            force_ldu;
  logic            alu_hs, ldu_hs;
  wr_req_t         grant;
  wr_req_t         wr_q, wr_d;
  logic            regwr_q, regwr_d;

  assign force_ldu = (starve_q == StarveMax);

  always_comb begin
    alu_ready = 1'b0;
    ldu_ready = 1'b0;
    if (rst_n) begin
      if (force_ldu) begin
        ldu_ready = 1'b1;
      end else begin
        alu_ready = 1'b1;
        ldu_ready = ~alu_valid;
      end
    end
  end

  assign alu_hs = alu_valid & alu_ready;
  assign ldu_hs = ldu_valid & ldu_ready;

  // Readies are mutually exclusive whenever both requesters are valid, so one grant at most.
  always_comb begin
    grant.addr = alu_addr;
    grant.data = alu_data;
    if (ldu_hs) begin
      grant.addr = ldu_addr;
      grant.data = ldu_data;
    end
  end

  always_comb begin
    starve_d = '0;
    if (ldu_valid && !ldu_ready) begin
      starve_d = force_ldu ? starve_q : starve_q + CntW'(1);
    end
  end

  always_comb begin
    wr_d    = wr_q;
    regwr_d = 1'b0;
    if (alu_hs || ldu_hs) begin
      wr_d    = grant;
      regwr_d = (grant.addr != REG_ZERO);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
      wr_q     <= '0;
      regwr_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      wr_q     <= wr_d;
      regwr_q  <= regwr_d;
    end
  end

  assign regWr   = regwr_q;
  assign addrWr  = wr_q.addr;
  assign wr_data = wr_q.data;

  wb_scoreboard u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_valid_i(issue_valid),
    .issue_addr_i (issue_addr),
    .issue_ready_o(issue_ready),
    .commit_i     (regwr_q),
    .commit_addr_i(wr_q.addr),
    .rd_addr0_i   (rd_addr0),
    .rd_addr1_i   (rd_addr1),
    .hazard_o     (hazard)
  );

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed and randomized checks of regfile_wb_ctrl against a behavioural reference model.
module tb_regfile_wb_ctrl;

  localparam int SM = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        ldu_valid, ldu_ready;
  logic [4:0]  ldu_addr;
  logic [31:0] ldu_data;
  logic        issue_valid, issue_ready;
  logic [4:0]  issue_addr;
  logic [4:0]  rd_addr0, rd_addr1;
  logic        hazard;
  logic        regWr;
  logic [4:0]  addrWr;
  logic [31:0] wr_data;

  regfile_wb_ctrl #(.STARVE_MAX(SM)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_addr   (alu_addr),
    .alu_data   (alu_data),
    .ldu_valid  (ldu_valid),
    .ldu_ready  (ldu_ready),
    .ldu_addr   (ldu_addr),
    .ldu_data   (ldu_data),
    .issue_valid(issue_valid),
    .issue_ready(issue_ready),
    .issue_addr (issue_addr),
    .rd_addr0   (rd_addr0),
    .rd_addr1   (rd_addr1),
    .hazard     (hazard),
    .regWr      (regWr),
    .addrWr     (addrWr),
    .wr_data    (wr_data)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          m_starve;
  bit          m_pend[32];
  bit          m_wr;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          m_known;
  bit          last_alu_hs, last_ldu_hs;

  // Samples of the DUT taken on the falling edge
  logic        s_alu_rdy, s_ldu_rdy, s_iss_rdy, s_haz, s_regwr;
  logic [4:0]  s_addr;
  logic [31:0] s_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_starve = 0;
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_wr    = 1'b0;
    m_addr  = '0;
    m_data  = '0;
    m_known = 1'b1;
    last_alu_hs = 1'b0;
    last_ldu_hs = 1'b0;
  endtask

  // One clock: check outputs against the model mid-cycle, then advance the model.
  task automatic cycle();
    bit e_alu, e_ldu, e_iss, e_haz, iss_hs;
    logic [4:0]  a;
    logic [31:0] d;
    if (!rst_n) model_reset();
    e_alu = 1'b0;
    e_ldu = 1'b0;
    e_iss = 1'b0;
    if (rst_n) begin
      e_alu = (m_starve < SM);
      e_ldu = (m_starve >= SM) || !alu_valid;
      e_iss = !m_pend[issue_addr];
    end
    e_haz = m_pend[rd_addr0] || m_pend[rd_addr1];
    @(negedge clk);
    s_alu_rdy = alu_ready;
    s_ldu_rdy = ldu_ready;
    s_iss_rdy = issue_ready;
    s_haz     = hazard;
    s_regwr   = regWr;
    s_addr    = addrWr;
    s_data    = wr_data;
    chk("alu_ready", {31'b0, s_alu_rdy}, {31'b0, e_alu});
    chk("ldu_ready", {31'b0, s_ldu_rdy}, {31'b0, e_ldu});
    chk("issue_ready", {31'b0, s_iss_rdy}, {31'b0, e_iss});
    chk("hazard", {31'b0, s_haz}, {31'b0, e_haz});
    chk("regWr", {31'b0, s_regwr}, {31'b0, m_wr});
    if (m_known) begin
      chk("addrWr", {27'b0, s_addr}, {27'b0, m_addr});
      chk("wr_data", s_data, m_data);
    end
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      last_alu_hs = alu_valid && e_alu;
      last_ldu_hs = ldu_valid && e_ldu;
      iss_hs      = issue_valid && e_iss;
      if (m_wr) m_pend[m_addr] = 1'b0;
      if (iss_hs && issue_addr != 5'd0) m_pend[issue_addr] = 1'b1;
      if (ldu_valid && !e_ldu) m_starve = (m_starve < SM) ? m_starve + 1 : SM;
      else m_starve = 0;
      if (last_alu_hs || last_ldu_hs) begin
        a = last_ldu_hs ? ldu_addr : alu_addr;
        d = last_ldu_hs ? ldu_data : alu_data;
        m_wr    = (a != 5'd0);
        m_addr  = a;
        m_data  = d;
        m_known = (a != 5'd0);
      end else begin
        m_wr = 1'b0;
      end
    end
    #1;
  endtask

  bit [5:0] alu_pat;

  initial begin
    rst_n       = 1'b0;
    alu_valid   = 1'b1;  alu_addr = 5'd1;  alu_data = 32'h11;
    ldu_valid   = 1'b1;  ldu_addr = 5'd2;  ldu_data = 32'h22;
    issue_valid = 1'b1;  issue_addr = 5'd3;
    rd_addr0    = 5'd3;  rd_addr1 = 5'd2;
    model_reset();

    // Reset held with every requester valid
    cycle();
    cycle();
    chk("rst_regWr", {31'b0, s_regwr}, 32'd0);
    chk("rst_alu_ready", {31'b0, s_alu_rdy}, 32'd0);
    chk("rst_hazard", {31'b0, s_haz}, 32'd0);
    alu_valid = 1'b0; ldu_valid = 1'b0; issue_valid = 1'b0;
    rst_n = 1'b1;
    cycle();
    chk("post_rst_alu_ready", {31'b0, s_alu_rdy}, 32'd1);

    // ALU-only write
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
    cycle();
    alu_valid = 1'b0;
    cycle();
    chk("alu_wr_en", {31'b0, s_regwr}, 32'd1);
    chk("alu_wr_addr", {27'b0, s_addr}, 32'd5);
    chk("alu_wr_data", s_data, 32'hDEADBEEF);
    cycle();
    chk("alu_wr_done", {31'b0, s_regwr}, 32'd0);

    // Starvation: both requesters busy for six cycles
    alu_pat   = 6'b110111;
    ldu_valid = 1'b1; ldu_addr = 5'd20; ldu_data = 32'hA5A5_0014;
    for (int i = 0; i < 6; i++) begin
      alu_valid = 1'b1; alu_addr = 5'(10 + i); alu_data = 32'(i);
      cycle();
      chk("starve_alu_grant", {31'b0, s_alu_rdy}, {31'b0, alu_pat[i]});
      chk("starve_ldu_grant", {31'b0, s_ldu_rdy}, {31'b0, ~alu_pat[i]});
    end
    alu_valid = 1'b0; ldu_valid = 1'b0;
    cycle();
    cycle();

    // Scoreboard: LDU op to r7 outstanding until its write commits
    issue_valid = 1'b1; issue_addr = 5'd7; rd_addr0 = 5'd7; rd_addr1 = 5'd0;
    cycle();
    issue_valid = 1'b0;
    cycle();
    chk("sb_hazard_set", {31'b0, s_haz}, 32'd1);
    chk("sb_issue_blocked", {31'b0, s_iss_rdy}, 32'd0);
    cycle();
    ldu_valid = 1'b1; ldu_addr = 5'd7; ldu_data = 32'h0000_0777;
    cycle();
    ldu_valid = 1'b0;
    cycle();
    chk("sb_commit_wr", {31'b0, s_regwr}, 32'd1);
    chk("sb_commit_addr", {27'b0, s_addr}, 32'd7);
    chk("sb_hazard_through_commit", {31'b0, s_haz}, 32'd1);
    cycle();
    chk("sb_hazard_cleared", {31'b0, s_haz}, 32'd0);
    chk("sb_issue_free", {31'b0, s_iss_rdy}, 32'd1);

    // Write to r9 committing on the same edge as a new issue to r9
    rd_addr0 = 5'd9;
    alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h0000_0999;
    cycle();
    alu_valid = 1'b0;
    issue_valid = 1'b1; issue_addr = 5'd9;
    cycle();
    chk("same_edge_commit_addr", {27'b0, s_addr}, 32'd9);
    chk("same_edge_issue_ready", {31'b0, s_iss_rdy}, 32'd1);
    issue_valid = 1'b0;
    cycle();
    chk("same_edge_set_wins", {31'b0, s_haz}, 32'd1);
    cycle();
    chk("same_edge_still_set", {31'b0, s_haz}, 32'd1);

    // Register 0 is never written and never pending
    alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'h1;
    issue_valid = 1'b1; issue_addr = 5'd0; rd_addr0 = 5'd0; rd_addr1 = 5'd0;
    cycle();
    chk("r0_alu_ready", {31'b0, s_alu_rdy}, 32'd1);
    alu_valid = 1'b0; issue_valid = 1'b0;
    cycle();
    chk("r0_no_write", {31'b0, s_regwr}, 32'd0);
    chk("r0_no_hazard", {31'b0, s_haz}, 32'd0);

    // Reset mid-operation drops the in-flight write and clears the scoreboard
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h3333;
    issue_valid = 1'b1; issue_addr = 5'd12; rd_addr1 = 5'd12;
    cycle();
    alu_valid = 1'b0; issue_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_regWr", {31'b0, regWr}, 32'd0);
    chk("mid_rst_hazard", {31'b0, hazard}, 32'd0);
    cycle();
    rst_n = 1'b1;
    cycle();

    // Randomized traffic obeying the hold-while-stalled rule
    for (int n = 0; n < 400; n++) begin
      if (!alu_valid || last_alu_hs) begin
        alu_valid = ($urandom_range(0, 2) != 0);
        alu_addr  = 5'($urandom_range(0, 15));
        alu_data  = $urandom;
      end
      if (!ldu_valid || last_ldu_hs) begin
        ldu_valid = ($urandom_range(0, 1) != 0);
        ldu_addr  = 5'($urandom_range(0, 15));
        ldu_data  = $urandom;
      end
      issue_valid = ($urandom_range(0, 3) == 0);
      issue_addr  = 5'($urandom_range(0, 15));
      rd_addr0    = 5'($urandom_range(0, 15));
      rd_addr1    = 5'($urandom_range(0, 15));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
